gzip_block_unpacker: RTL
========================

Name: gzip_block_unpacker

Overview:
- Front end of the gzip compression path: pops words from the input FIFO, parses the per-block header word (BFINAL, BTYPE, LENGTH), and serialises the payload into a byte stream with valid/ready for the LZ77 encoder.
- Generalises the fixed 32-bit, single-order input handling to N byte lanes, a selectable lane order, multi-block sequencing and explicit length/format error handling.

Parameters:
- LANES, 4, bytes per input FIFO word; legal values 4 or 8.
- LANE_ORDER, 0, 0 = lane0 (bits 7:0) emitted first; 1 = highest lane emitted first.
- MAX_LEN, 65535, largest legal LENGTH in bytes; larger values are an error.
- LEN_WIDTH, 24, width of the LENGTH field and its counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- clear  in  1  synchronous soft restart to IDLE; does not touch the FIFO
- start  in  1  pulse; leaves IDLE/DONE/ERR and begins header fetch
- din_fifo_in  in  8*LANES  FIFO read data; valid one cycle after rd_en_fifo_in
- empty_fifo_in  in  1  FIFO empty
- rd_en_fifo_in  out  1  FIFO pop
- byte_out  out  8  payload byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  consumer accepts the byte when valid & ready
- byte_last  out  1  qualifies the final byte of a block
- blk_start  out  1  one-cycle pulse when a header is accepted
- blk_btype  out  2  BTYPE of the current block; held until the next header
- blk_final  out  1  BFINAL of the current block; held
- blk_len  out  LEN_WIDTH  LENGTH of the current block; held
- blk_done  out  1  one-cycle pulse after a block's last byte, or at once for LENGTH=0
- busy  out  1  high in every state except IDLE, DONE and ERR
- err  out  1  sticky error flag; cleared by start or clear

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- Header word, lanes numbered from bits 7:0:
  - lane0 = {5'b0, BTYPE[1:0], BFINAL}
  - lane1 = LENGTH[23:16], lane2 = LENGTH[15:8], lane3 = LENGTH[7:0]
  - lanes 4..LANES-1 ignored
  - Header lane mapping is independent of LANE_ORDER.
- States: IDLE, HDR_RD, HDR_WAIT, DAT_RD, DAT_WAIT, EMIT, DONE, ERR.
- IDLE: start -> HDR_RD.
- HDR_RD: if !empty_fifo_in, assert rd_en_fifo_in for exactly 1 cycle -> HDR_WAIT.
- HDR_WAIT: latch the header.
  - If BTYPE==2'b11 or LENGTH>MAX_LEN: err=1 -> ERR.
  - Else: blk_start=1, counter=LENGTH.
    - LENGTH=0: blk_done=1 same cycle, then -> DONE if BFINAL else -> HDR_RD.
    - LENGTH>0: -> DAT_RD.
- DAT_RD / DAT_WAIT: pop one word (same 1-cycle read latency) and load the lane shift register -> EMIT.
- EMIT:
  - Present lane 0..LANES-1 in LANE_ORDER; advance one lane and decrement the counter only on byte_valid & byte_ready.
  - byte_valid and byte_out stay stable while byte_ready=0.
  - Counter reaches 0: the byte carrying it has byte_last=1; remaining lanes of that word are discarded (padding). The next cycle pulses blk_done, then -> DONE if BFINAL, else -> HDR_RD.
  - Word exhausted with counter>0: -> DAT_RD.
- Never pops the FIFO while empty_fifo_in=1 or during EMIT.
- Throughput: at most one byte per cycle.
- Word turnaround: each word costs 2 bubble cycles (RD, WAIT); no prefetch.
- DONE, ERR: hold; only start or clear exits.
- clear mid-block: state -> IDLE next edge; byte_valid drops immediately; the FIFO holds unconsumed words.
- rst_n asserted mid-operation: asynchronous return to reset values.
- start while busy=1: ignored.
- Counter is LEN_WIDTH bits and never wraps: no decrement at 0.

Test Plan:
- LANES=4, LANE_ORDER=0; header lane0=8'h03, LENGTH=4; data word lanes {"x","b","c","d"} with byte_ready=1:
  - bytes x,b,c,d out; byte_last on d
  - blk_btype=01, blk_final=1
  - blk_done pulse, then DONE; exactly 2 FIFO pops
- Header LENGTH=6 (BFINAL=0), then LENGTH=5 (BFINAL=1), with padding lanes filled 8'h00:
  - 6 then 5 bytes emitted; padding never emitted
  - two blk_start and two blk_done pulses; ends in DONE
- byte_ready toggled 1-0-1-0 during EMIT: byte_out stable across stalls, no byte lost or duplicated, counter decrements only on handshakes.
- LENGTH=0 with BFINAL=1: blk_start and blk_done in the same cycle, no byte_valid, DONE after 1 pop.
- BTYPE=11, or LENGTH=MAX_LEN+1: err=1, state ERR, no bytes emitted; a following start clears err.
- LANES=8, LANE_ORDER=1, LENGTH=10: first word emits lanes 7..0, second emits lanes 7,6 with byte_last on lane 6; clear asserted mid-second-word returns to IDLE with byte_valid=0 next cycle.

Source files
------------

// File: rtl/gzip_block_unpacker.sv
// Block unpacker for the gzip front end: pops FIFO words, parses each block header
// and streams the payload bytes lane by lane to the LZ77 encoder.
module gzip_block_unpacker #(
  parameter int LANES      = 4,
  parameter int LANE_ORDER = 0,
  parameter int MAX_LEN    = 65535,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [8*LANES-1:0]   din_fifo_in,
  input  logic                 empty_fifo_in,
  output logic                 rd_en_fifo_in,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 blk_start,
  output logic [1:0]           blk_btype,
  output logic                 blk_final,
  output logic [LEN_WIDTH-1:0] blk_len,
  output logic                 blk_done,
  output logic                 busy,
  output logic                 err
);

  // state    | meaning
  // IDLE     | waiting for start
  // HDR_RD   | pop header word when FIFO not empty
  // HDR_WAIT | header on din; validate and latch
  // DAT_RD   | pop payload word when FIFO not empty
  // DAT_WAIT | payload on din; load lane shifter
  // EMIT     | present lanes one byte per handshake
  // DONE     | final block finished; hold
  // ERR      | bad BTYPE or LENGTH; hold
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_RD, S_HDR_WAIT, S_DAT_RD, S_DAT_WAIT, S_EMIT, S_DONE, S_ERR
  } state_t;

  localparam int W  = 8 * LANES;
  localparam int LW = $clog2(LANES) + 1;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         shreg_q, shreg_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [1:0]           btype_q, btype_d;
  logic                 final_q, final_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 err_q, err_d;
  logic                 bstart_q, bstart_d;
  logic                 bdone_q, bdone_d;

  logic [23:0]          hdr_len24;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [1:0]           hdr_btype;
  logic                 hdr_final;
  logic                 hdr_bad;
  logic                 hs;

  // Header lanes are fixed to bit positions regardless of LANE_ORDER.
  assign hdr_final = din_fifo_in[0];
  assign hdr_btype = din_fifo_in[2:1];
  assign hdr_len24 = {din_fifo_in[15:8], din_fifo_in[23:16], din_fifo_in[31:24]};
  assign hdr_len   = LEN_WIDTH'(hdr_len24);
  assign hdr_bad   = (hdr_btype == 2'b11) || ({8'b0, hdr_len24} > 32'(MAX_LEN));

  // byte_valid is gated by clear so a soft restart withdraws the byte at once.
  assign byte_valid = (state_q == S_EMIT) && !clear;
  assign hs         = byte_valid && byte_ready;
  assign byte_last  = byte_valid && (cnt_q == LEN_WIDTH'(1));
  assign byte_out   = (LANE_ORDER == 0) ? shreg_q[7:0] : shreg_q[W-1 -: 8];
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign err        = err_q;
  assign blk_start  = bstart_q;
  assign blk_done   = bdone_q;
  assign blk_btype  = btype_q;
  assign blk_final  = final_q;
  assign blk_len    = len_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    lane_d        = lane_q;
    btype_d       = btype_q;
    final_d       = final_q;
    len_d         = len_q;
    err_d         = err_q;
    bstart_d      = 1'b0;
    bdone_d       = 1'b0;
    rd_en_fifo_in = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_RD;
          err_d   = 1'b0;
        end
      end
      S_HDR_RD: begin
        if (!empty_fifo_in) begin
          rd_en_fifo_in = 1'b1;
          state_d       = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        if (hdr_bad) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          bstart_d = 1'b1;
          btype_d  = hdr_btype;
          final_d  = hdr_final;
          len_d    = hdr_len;
          cnt_d    = hdr_len;
          if (hdr_len == '0) begin
            bdone_d = 1'b1;
            state_d = hdr_final ? S_DONE : S_HDR_RD;
          end else begin
            state_d = S_DAT_RD;
          end
        end
      end
      S_DAT_RD: begin
        if (!empty_fifo_in) begin
          rd_en_fifo_in = 1'b1;
          state_d       = S_DAT_WAIT;
        end
      end
      S_DAT_WAIT: begin
        shreg_d = din_fifo_in;
        lane_d  = LW'(LANES);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (hs) begin
          if (cnt_q != '0) cnt_d = cnt_q - LEN_WIDTH'(1);
          shreg_d = (LANE_ORDER == 0) ? (shreg_q >> 8) : (shreg_q << 8);
          lane_d  = lane_q - LW'(1);
          // Remaining lanes of the final word are padding and are dropped.
          if (cnt_q == LEN_WIDTH'(1)) begin
            bdone_d = 1'b1;
            state_d = final_q ? S_DONE : S_HDR_RD;
          end else if (lane_q == LW'(1)) begin
            state_d = S_DAT_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d       = S_IDLE;
      err_d         = 1'b0;
      bstart_d      = 1'b0;
      bdone_d       = 1'b0;
      rd_en_fifo_in = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      lane_q   <= '0;
      btype_q  <= '0;
      final_q  <= 1'b0;
      len_q    <= '0;
      err_q    <= 1'b0;
      bstart_q <= 1'b0;
      bdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      lane_q   <= lane_d;
      btype_q  <= btype_d;
      final_q  <= final_d;
      len_q    <= len_d;
      err_q    <= err_d;
      bstart_q <= bstart_d;
      bdone_q  <= bdone_d;
    end
  end

endmodule
